// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
package uart_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam logic [15:0] DEFAULT_DIV = 16'd868;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO; on simultaneous push and pop the head is read before the
// new entry lands, so a push into a full FIFO succeeds when it is also popped.
module uart_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/DIV register window,
// TX FIFO and a bit-timing state machine with a registered serial output.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = uart_pkg::DEFAULT_DIV
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wr_dat,
  input  logic        rd_en,
  input  logic        wr_en,
  output logic [31:0] m_rd_dat,
  output logic        addr_hit,
  output logic        txd
);

  import uart_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    offset;
  logic          wr_txdata;
  logic          wr_status;
  logic          wr_div;

  logic          fifo_pop;
  logic [7:0]    fifo_rd;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          ovf;
  logic [15:0]   div_reg;

  tx_state_e     state, state_n;
  logic [15:0]   bit_cnt, bit_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shifter, shifter_n;
  logic          txd_n;
  logic          tick;

  assign addr_hit  = (m_addr[31:4] == BASE_ADDR[31:4]);
  assign offset    = m_addr[3:2];
  assign wr_txdata = wr_en && addr_hit && (offset == OFF_TXDATA);
  assign wr_status = wr_en && addr_hit && (offset == OFF_STATUS);
  assign wr_div    = wr_en && addr_hit && (offset == OFF_DIV);

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (wr_txdata),
    .pop     (fifo_pop),
    .wr_data (m_wr_dat[7:0]),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf     <= 1'b0;
      div_reg <= DEFAULT_DIV;
    end else begin
      if (wr_txdata && fifo_full && !fifo_pop) ovf <= 1'b1;
      else if (wr_status && m_wr_dat[ST_OVF])  ovf <= 1'b0;
      if (wr_div) div_reg <= (m_wr_dat[15:0] == 16'd0) ? 16'd1 : m_wr_dat[15:0];
    end
  end

  always_comb begin
    m_rd_dat = '0;
    if (rd_en && addr_hit) begin
      case (offset)
        OFF_STATUS: begin
          m_rd_dat[ST_FULL]                = fifo_full;
          m_rd_dat[ST_EMPTY]               = fifo_empty;
          m_rd_dat[ST_BUSY]                = (state != S_IDLE);
          m_rd_dat[ST_OVF]                 = ovf;
          m_rd_dat[ST_CNT_LSB +: CW]       = fifo_count;
        end
        OFF_DIV: m_rd_dat[15:0] = div_reg;
        default: m_rd_dat = '0;
      endcase
    end
  end

  assign tick = (bit_cnt == 16'd0);

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    bit_idx_n = bit_idx;
    shifter_n = shifter;
    fifo_pop  = 1'b0;
    txd_n     = 1'b1;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shifter_n = fifo_rd;
          bit_cnt_n = div_reg - 16'd1;
          state_n   = S_START;
        end
      end
      S_START: begin
        txd_n = 1'b0;
        if (tick) begin
          bit_cnt_n = div_reg - 16'd1;
          bit_idx_n = 3'd0;
          state_n   = S_DATA;
        end else begin
          bit_cnt_n = bit_cnt - 16'd1;
        end
      end
      S_DATA: begin
        txd_n = shifter[0];
        if (tick) begin
          bit_cnt_n = div_reg - 16'd1;
          shifter_n = {1'b0, shifter[7:1]};
          if (bit_idx == 3'd7) state_n = S_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end else begin
          bit_cnt_n = bit_cnt - 16'd1;
        end
      end
      S_STOP: begin
        if (tick) state_n = S_IDLE;
        else      bit_cnt_n = bit_cnt - 16'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // txd is taken from the current state, so the line lags the FSM by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shifter <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      shifter <= shifter_n;
      txd     <= txd_n;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register vector table, txd frame
// scoreboard and hand-written sequences for latency, overflow and reset.
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX  = 32'h1000_0000;
  localparam logic [31:0] A_ST  = 32'h1000_0004;
  localparam logic [31:0] A_DIV = 32'h1000_0008;

  logic        clk;
  logic        reset;
  logic [31:0] m_addr;
  logic [31:0] m_wr_dat;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] m_rd_dat;
  logic        addr_hit;
  logic        txd;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  int         mon_div;
  logic       mon_abort;
  logic       line [0:127];
  int         md;
  int         bad;
  int         idx;
  logic [7:0] mb;
  logic       e;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[12];

  mmio_uart_tx dut (
    .clk      (clk),
    .reset    (reset),
    .m_addr   (m_addr),
    .m_wr_dat (m_wr_dat),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .m_rd_dat (m_rd_dat),
    .addr_hit (addr_hit),
    .txd      (txd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    m_addr = a; m_wr_dat = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    m_addr = a; rd_en = 1'b1;
    #1;
    d = m_rd_dat;
    rd_en = 1'b0;
  endtask

  task automatic rdwr(input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] d, output logic h);
    m_addr = a; m_wr_dat = wd; rd_en = 1'b1; wr_en = 1'b1;
    #1;
    d = m_rd_dat; h = addr_hit;
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d frames outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Frame monitor: captures a whole frame from the start bit and compares it
  // cycle by cycle against the waveform built from the next expected byte.
  always begin
    @(negedge clk);
    if (txd === 1'b0) begin
      md = mon_div;
      line[0] = txd;
      for (int c = 1; c <= 10*md; c++) begin
        @(negedge clk);
        line[c] = txd;
      end
      if (!mon_abort) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL frame_unexpected: got a frame, expected none");
        end else begin
          mb = exp_q.pop_front();
          bad = 0;
          for (int c = 0; c <= 10*md; c++) begin
            idx = c/md - 1;
            if (c < md)        e = 1'b0;
            else if (c < 9*md) e = mb[idx[2:0]];
            else               e = 1'b1;
            if (line[c] !== e) bad++;
          end
          chk($sformatf("frame_%02h_bad_cycles", mb), bad, 0);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        h;
    int          low;

    reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; m_addr = '0; m_wr_dat = '0;
    mon_div = 4; mon_abort = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_txd", txd, 1);

    vecs[0]  = '{1'b1, 1'b0, 32'h1000_0004, 32'h0,         32'h0000_0002, 1'b1};
    vecs[1]  = '{1'b1, 1'b0, 32'h1000_0008, 32'h0,         32'h0000_0364, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0,         1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h1000_0000, 32'h0,         32'h0,         1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'h1000_000C, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[5]  = '{1'b1, 1'b0, 32'h1000_000C, 32'h0,         32'h0,         1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h1000_0008, 32'h0,         32'h0000_0364, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'h1000_000A, 32'hABCD_1234, 32'h0,         1'b1};
    vecs[8]  = '{1'b1, 1'b0, 32'h1000_000B, 32'h0,         32'h0000_1234, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 32'h1000_0008, 32'h0,         32'h0000_1234, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h1000_0008, 32'h0,         32'h0000_0001, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h2000_0004, 32'h0,         32'h0,         1'b0};

    for (int i = 0; i < 12; i++) begin
      m_addr = vecs[i].addr; m_wr_dat = vecs[i].wdata;
      rd_en = vecs[i].rd; wr_en = vecs[i].wr;
      #1;
      chk($sformatf("vec%0d_rd", i), m_rd_dat, vecs[i].exp_rd);
      chk($sformatf("vec%0d_hit", i), addr_hit, vecs[i].exp_hit);
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
    end

    // DIV is now 1: a single frame spans exactly 10 cycles
    mon_div = 1;
    exp_q.push_back(8'hA5);
    wr(A_TX, 32'hA5);
    wait_drain(100);
    repeat (3) @(negedge clk);
    rd(A_ST, d); chk("div1_status_after", d, 32'h2);

    wr(A_DIV, 32'd4);
    mon_div = 4;
    rd(A_DIV, d); chk("div4_readback", d, 32'd4);

    exp_q.push_back(8'h55);
    wr(A_TX, 32'h55);
    chk("lat_c0_txd", txd, 1);
    @(negedge clk);
    chk("lat_c1_txd", txd, 1);
    rd(A_ST, d); chk("lat_c1_busy", d[2], 1);
    @(negedge clk);
    chk("lat_c2_txd", txd, 0);
    for (int k = 0; k < 9; k++) begin
      repeat (4) @(negedge clk);
      rd(A_ST, d); chk($sformatf("busy_%0d", k), d[2], 1);
    end
    wait_drain(200);
    repeat (3) @(negedge clk);
    rd(A_ST, d); chk("x55_status_after", d, 32'h2);

    for (int i = 0; i < 10; i++) begin
      if (i < 9) exp_q.push_back(8'(i));
      wr(A_TX, i);
    end
    rd(A_ST, d); chk("ovf_status_full", d, 32'h8D);
    wr(A_ST, 32'h08);
    rd(A_ST, d); chk("ovf_cleared", d, 32'h85);
    rdwr(A_TX, 32'hEE, d, h);
    chk("rdwr_tx_rd", d, 0);
    rd(A_ST, d); chk("rdwr_tx_ovf", d, 32'h8D);
    rdwr(32'h1000_0014, 32'h08, d, h);
    chk("outside_rd", d, 0);
    chk("outside_hit", h, 0);
    rd(A_ST, d); chk("outside_no_effect", d, 32'h8D);
    wr(A_ST, 32'h08);
    wait_drain(1000);
    repeat (50) @(negedge clk);
    rd(A_ST, d); chk("burst_status_after", d, 32'h2);

    exp_q.push_back(8'h55);
    exp_q.push_back(8'h33);
    wr(A_TX, 32'h55);
    wr(A_TX, 32'h33);
    repeat (17) @(negedge clk);
    chk("pre_reset_bit3", txd, 0);
    mon_abort = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_txd", txd, 1);
    reset = 1'b0;
    exp_q.delete();
    rd(A_ST, d);  chk("rst_status", d, 32'h2);
    rd(A_DIV, d); chk("rst_div", d, 32'h364);
    low = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd !== 1'b1) low++;
    end
    chk("rst_no_frame", low, 0);
    mon_abort = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
